// File: rtl/data_req_router.sv
// Routes the CPU data-side request to the data cache or the uncached bridge
// based on the MMU no_dcache flag, with one transaction outstanding at a time.
module data_req_router (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    input  logic        cpu_data_no_cache,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic [31:0] cpu_data_rdata,

    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok,
    input  logic [31:0] cache_data_rdata,

    output logic        uncache_data_req,
    output logic        uncache_data_wr,
    output logic [1:0]  uncache_data_size,
    output logic [31:0] uncache_data_addr,
    output logic [31:0] uncache_data_wdata,
    input  logic        uncache_data_addr_ok,
    input  logic        uncache_data_data_ok,
    input  logic [31:0] uncache_data_rdata
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CACHE_WAIT = 2'd1,
        UNC_REQ    = 2'd2,
        UNC_WAIT   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        capture;

    logic        unc_wr;
    logic [1:0]  unc_size;
    logic [31:0] unc_addr;
    logic [31:0] unc_wdata;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            unc_wr    <= 1'b0;
            unc_size  <= 2'd0;
            unc_addr  <= 32'd0;
            unc_wdata <= 32'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                unc_wr    <= cpu_data_wr;
                unc_size  <= cpu_data_size;
                unc_addr  <= cpu_data_addr;
                unc_wdata <= cpu_data_wdata;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves an output unassigned (no latches).
        state_next       = state;
        capture          = 1'b0;
        cpu_data_addr_ok = 1'b0;
        cpu_data_data_ok = 1'b0;
        cpu_data_rdata   = 32'd0;
        cache_data_req   = 1'b0;
        uncache_data_req = 1'b0;

        // Nothing is accepted while reset is held, so no request is silently dropped.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (cpu_data_req && !cpu_data_no_cache) begin
                        cache_data_req   = 1'b1;
                        cpu_data_addr_ok = cache_data_addr_ok;
                        if (cache_data_addr_ok) state_next = CACHE_WAIT;
                    end else if (cpu_data_req && cpu_data_no_cache) begin
                        cpu_data_addr_ok = 1'b1;
                        capture          = 1'b1;
                        state_next       = UNC_REQ;
                    end
                end
                CACHE_WAIT: begin
                    if (cache_data_data_ok) begin
                        cpu_data_data_ok = 1'b1;
                        cpu_data_rdata   = cache_data_rdata;
                        state_next       = IDLE;
                    end
                end
                UNC_REQ: begin
                    uncache_data_req = 1'b1;
                    if (uncache_data_addr_ok) state_next = UNC_WAIT;
                end
                UNC_WAIT: begin
                    if (uncache_data_data_ok) begin
                        cpu_data_data_ok = 1'b1;
                        cpu_data_rdata   = uncache_data_rdata;
                        state_next       = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign cache_data_wr      = cpu_data_wr;
    assign cache_data_size    = cpu_data_size;
    assign cache_data_addr    = cpu_data_addr;
    assign cache_data_wdata   = cpu_data_wdata;

    assign uncache_data_wr    = unc_wr;
    assign uncache_data_size  = unc_size;
    assign uncache_data_addr  = unc_addr;
    assign uncache_data_wdata = unc_wdata;

endmodule

// File: doc/data_req_router.md
# data_req_router

Routes the CPU data-side SRAM-like request, already translated to a physical address by the MMU, to either the data cache port or the uncached bridge port. Selection uses the MMU's `no_dcache` flag. The block allows one outstanding transaction and returns the response from whichever path was chosen. Uncached requests are registered before they go out on the uncached port, which cuts the MMU-to-bus timing path. It sits between the MMU and the d-cache / uncached AXI bridge.

## Interface
No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `cpu_data_req` in 1: CPU request valid.
- `cpu_data_wr` in 1: 1 = write, 0 = read.
- `cpu_data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `cpu_data_addr` in 32: physical address from the MMU.
- `cpu_data_wdata` in 32: write data.
- `cpu_data_no_cache` in 1: MMU `no_dcache` flag; 1 selects the uncached path.
- `cpu_data_addr_ok` out 1: request accepted this cycle.
- `cpu_data_data_ok` out 1: response valid this cycle.
- `cpu_data_rdata` out 32: read data, valid only with `cpu_data_data_ok`.
- `cache_data_req` out 1, `cache_data_wr` out 1, `cache_data_size` out 2, `cache_data_addr` out 32, `cache_data_wdata` out 32: cache request port.
- `cache_data_addr_ok` in 1, `cache_data_data_ok` in 1, `cache_data_rdata` in 32: cache response port.
- `uncache_data_req` out 1, `uncache_data_wr` out 1, `uncache_data_size` out 2, `uncache_data_addr` out 32, `uncache_data_wdata` out 32: uncached request port.
- `uncache_data_addr_ok` in 1, `uncache_data_data_ok` in 1, `uncache_data_rdata` in 32: uncached response port.

## Operation
- A handshake occurs on any port when `req & addr_ok` are both high in the same cycle.
- State machine states: IDLE, CACHE_WAIT, UNC_REQ, UNC_WAIT.
- **IDLE, cached request** (`cpu_data_req=1`, `no_cache=0`):
  - `cache_data_req = 1`.
  - `cpu_data_addr_ok = cache_data_addr_ok`, combinational.
  - On handshake, go to CACHE_WAIT.
- **Cache port payload:** `cache_data_wr/size/addr/wdata` always mirror the CPU fields combinationally.
- **IDLE, uncached request** (`cpu_data_req=1`, `no_cache=1`):
  - `cpu_data_addr_ok = 1` unconditionally.
  - wr/size/addr/wdata are latched into internal registers.
  - Next state is UNC_REQ.
  - `uncache_data_req` stays 0 in this cycle.
- **IDLE, no request:** all req and ok outputs are 0.
- **CACHE_WAIT:**
  - `cpu_data_addr_ok = 0` and `cache_data_req = 0`.
  - When `cache_data_data_ok = 1`: `cpu_data_data_ok = 1`, `cpu_data_rdata = cache_data_rdata` (combinational pass-through), and the next state is IDLE.
- **UNC_REQ:**
  - `uncache_data_req = 1`.
  - Uncached payload outputs come from the latched registers, never directly from the CPU inputs.
  - On `uncache_data_addr_ok`, go to UNC_WAIT.
  - The block holds in UNC_REQ indefinitely while `addr_ok = 0`.
- **UNC_WAIT:**
  - `uncache_data_req = 0`.
  - When `uncache_data_data_ok = 1`: `cpu_data_data_ok = 1`, `cpu_data_rdata = uncache_data_rdata`, and the next state is IDLE.
- **Write responses:** writes also complete with a `data_ok`. `rdata` is don't-care for writes but must be driven as 0 whenever `cpu_data_data_ok = 0`.
- **Response filtering:** `data_ok` from the port not selected by the current state is ignored. This includes any `data_ok` seen in IDLE or UNC_REQ.
- **Uncached payload register hold:** the latched registers hold their value outside the capture cycle.
- **Uncached payload outputs outside UNC_REQ:** they show the last latched value.

## Timing
- **Reset:**
  - State is IDLE and all payload registers are 0.
  - Every output req, `addr_ok` and `data_ok` is 0.
  - `cpu_data_rdata` is 0.
  - `uncache_data_addr/wdata/size/wr` are 0.
- **Cached path:**
  - The CPU handshake in cycle N coincides with the cache handshake.
  - A cache `data_ok` in cycle M > N gives CPU `data_ok` in cycle M, with zero added latency.
  - A `data_ok` in the handshake cycle N itself is not sampled; downstream must respond at the earliest in N+1.
- **Uncached path:**
  - CPU accept in cycle N; `uncache_data_req` is high from N+1.
  - Bridge `addr_ok` in cycle K ≥ N+1; `data_ok` in cycle L > K gives CPU `data_ok` in cycle L.
- **Back-to-back requests:** the earliest next CPU acceptance is the cycle after `cpu_data_data_ok`. No acceptance occurs in the `data_ok` cycle itself, which gives one bubble.
- **Reset mid-operation:** `rst` asserted in any state forces IDLE on the next edge. The pending response is dropped and no `data_ok` is emitted for it.
- **Simultaneous events:** `cpu_data_req` and a stale `data_ok` arriving together in IDLE means the request is handled normally and the `data_ok` is ignored.

## Test plan
- **Cached read:** addr 0x1FC0_0100, `no_cache=0`, cache `addr_ok=1` in the same cycle, `data_ok` 2 cycles later with rdata 0xDEADBEEF → `cpu_data_addr_ok` in the request cycle; `cpu_data_data_ok` and rdata 0xDEADBEEF exactly 2 cycles later; `uncache_data_req` never asserted.
- **Uncached write:** addr 0x1FAF_F000, wdata 0x12345678, size 2, `no_cache=1`; bridge `addr_ok` held low 3 cycles → `cpu_data_addr_ok` immediate; `uncache_data_req` high for 4 cycles with stable addr/wdata even though the CPU inputs change after acceptance; `data_ok` returns CPU `data_ok` in the same cycle.
- **Back-to-back alternating:** cached, then uncached, then cached requests with `cpu_data_req` held high → exactly one bubble after each `data_ok`; each response's rdata comes from the correct port.
- **Spurious response:** `uncache_data_data_ok=1` with rdata 0xFFFF_FFFF during CACHE_WAIT → ignored; only the cache response is forwarded to the CPU.
- **Reset mid-operation:** `rst` asserted in UNC_WAIT, then the bridge `data_ok` arrives after reset → no `cpu_data_data_ok`; all outputs are 0 after the reset edge; a subsequent request is accepted normally.
- **Cache stall:** cache `addr_ok=0` for 5 cycles → `cpu_data_addr_ok=0` for those 5 cycles; the state stays IDLE; the handshake completes on the 6th cycle.
